// File: rtl/vc_input_buffer_mc_if.sv
`default_nettype none
// ============================================================
// Module  : vc_input_buffer_mc_if
// Brief   : Flit input/output bundle of the VC input buffer.
// Revision: 1.0
// ============================================================
interface vc_input_buffer_mc_if #(
  parameter int NUM_VC     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int FLIT_WIDTH = 34
);
  localparam int VC_W   = $clog2(NUM_VC);
  localparam int OCUP_W = $clog2(FIFO_DEPTH + 1);

  logic [VC_W-1:0]          vc_id_i;
  logic [FLIT_WIDTH-1:0]    fdata_i;
  logic                     valid_i;
  logic [NUM_VC-1:0]        ready_o;
  logic [FLIT_WIDTH-1:0]    fdata_o;
  logic [VC_W-1:0]          vc_id_o;
  logic                     valid_o;
  logic                     ready_i;
  logic [NUM_VC*OCUP_W-1:0] ocup_o;

  modport master (
    output vc_id_i, fdata_i, valid_i, ready_i,
    input  ready_o, fdata_o, vc_id_o, valid_o, ocup_o
  );

  modport slave (
    input  vc_id_i, fdata_i, valid_i, ready_i,
    output ready_o, fdata_o, vc_id_o, valid_o, ocup_o
  );
endinterface
`default_nettype wire

// File: rtl/vc_input_buffer_mc.sv
`default_nettype none
// ============================================================
// Module  : vc_input_buffer_mc
// Brief   : NoC input buffer with per-VC FIFOs, route locking and
//           round-robin (optionally wormhole) output arbitration.
// Revision: 1.0
// ============================================================
module vc_input_buffer_mc #(
  parameter int NUM_VC     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int FLIT_WIDTH = 34,
  parameter int PKT_ARB    = 1
) (
  input  logic                clk,
  input  logic                arst,
  vc_input_buffer_mc_if.slave bus
);
  localparam int VC_W   = $clog2(NUM_VC);
  localparam int PTR_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int AW     = PTR_W - 1;
  localparam int OCUP_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [VC_W:0] c_num_vc      = (VC_W+1)'(NUM_VC);
  localparam logic [1:0]    c_type_head   = 2'b00;
  localparam logic [1:0]    c_type_tail   = 2'b10;
  localparam logic [1:0]    c_type_single = 2'b11;

  typedef enum logic [0:0] {ST_FREE = 1'b0, ST_PKT = 1'b1} state_t;

  logic [FLIT_WIDTH-1:0] r_mem  [NUM_VC][FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr [NUM_VC];
  logic [PTR_W-1:0]      r_rptr [NUM_VC];
  logic [NUM_VC-1:0]     r_lock;
  logic [VC_W-1:0]       r_rr;
  logic [VC_W-1:0]       r_gnt;
  logic                  r_hold;
  state_t                r_state;
  state_t                w_state_nxt;

  logic [NUM_VC-1:0]        w_empty, w_full, w_ready, w_wr_vc, w_rd_vc;
  logic [1:0]               w_in_type, w_out_type;
  logic                     w_in_head_like, w_wr;
  logic [VC_W:0]            w_sum, w_gnt_inc;
  logic [VC_W-1:0]          w_rr_gnt, w_gnt, w_rr_nxt;
  logic                     w_rr_any, w_valid, w_xfer, w_rr_upd;
  logic [FLIT_WIDTH-1:0]    w_head_flit;
  logic [NUM_VC*OCUP_W-1:0] w_ocup;

  assign w_in_type      = bus.fdata_i[FLIT_WIDTH-1 -: 2];
  assign w_in_head_like = (w_in_type == c_type_head) || (w_in_type == c_type_single);
  assign w_wr           = bus.valid_i && ({1'b0, bus.vc_id_i} < c_num_vc) && w_ready[bus.vc_id_i];

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign w_empty[v] = (r_wptr[v] == r_rptr[v]);
    assign w_full[v]  = (r_wptr[v][AW-1:0] == r_rptr[v][AW-1:0]) && (r_wptr[v][AW] != r_rptr[v][AW]);
    // A locked VC is mid-packet: only body/tail may follow.
    assign w_ready[v] = !w_full[v] && !(r_lock[v] && w_in_head_like);
    assign w_wr_vc[v] = w_wr && (bus.vc_id_i == VC_W'(v));
    assign w_rd_vc[v] = w_xfer && (w_gnt == VC_W'(v));
  end

  always_comb begin
    w_ocup = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      w_ocup[v*OCUP_W +: OCUP_W] = OCUP_W'(r_wptr[v] - r_rptr[v]);
    end
  end

  // Descending scan so the closest VC to r_rr wins the last assignment.
  always_comb begin
    w_rr_gnt = '0;
    w_rr_any = 1'b0;
    w_sum    = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      w_sum = {1'b0, r_rr} + (VC_W+1)'(i);
      if (w_sum >= c_num_vc) w_sum = w_sum - c_num_vc;
      if (!w_empty[w_sum[VC_W-1:0]]) begin
        w_rr_gnt = w_sum[VC_W-1:0];
        w_rr_any = 1'b1;
      end
    end
  end

  always_comb begin
    if (r_state == ST_PKT || r_hold) begin
      w_gnt   = r_gnt;
      w_valid = !w_empty[r_gnt];
    end else begin
      w_gnt   = w_rr_gnt;
      w_valid = w_rr_any;
    end
  end

  assign w_head_flit = r_mem[w_gnt][r_rptr[w_gnt][AW-1:0]];
  assign w_out_type  = w_head_flit[FLIT_WIDTH-1 -: 2];
  assign w_xfer      = w_valid && bus.ready_i;
  assign w_gnt_inc   = {1'b0, w_gnt} + (VC_W+1)'(1);
  assign w_rr_nxt    = (w_gnt_inc == c_num_vc) ? '0 : w_gnt_inc[VC_W-1:0];
  // The pointer only moves once the grant is free again (tail or non-packet flit).
  assign w_rr_upd    = w_xfer && (w_state_nxt == ST_FREE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FREE: if (w_xfer && (PKT_ARB != 0) && (w_out_type == c_type_head)) w_state_nxt = ST_PKT;
      ST_PKT:  if (w_xfer && (w_out_type == c_type_tail)) w_state_nxt = ST_FREE;
      default: w_state_nxt = ST_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) r_state <= ST_FREE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        r_wptr[v] <= '0;
        r_rptr[v] <= '0;
      end
      r_lock <= '0;
      r_rr   <= '0;
      r_gnt  <= '0;
      r_hold <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (w_wr_vc[v]) begin
          r_wptr[v] <= r_wptr[v] + PTR_W'(1);
          if (w_in_type == c_type_head)      r_lock[v] <= 1'b1;
          else if (w_in_type == c_type_tail) r_lock[v] <= 1'b0;
        end
        if (w_rd_vc[v]) r_rptr[v] <= r_rptr[v] + PTR_W'(1);
      end
      if (w_rr_upd) r_rr <= w_rr_nxt;
      r_gnt  <= w_gnt;
      r_hold <= w_valid && !bus.ready_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst && w_wr) r_mem[bus.vc_id_i][r_wptr[bus.vc_id_i][AW-1:0]] <= bus.fdata_i;
  end

  assign bus.ready_o = w_ready;
  assign bus.valid_o = w_valid;
  assign bus.fdata_o = w_valid ? w_head_flit : '0;
  assign bus.vc_id_o = w_valid ? w_gnt : '0;
  assign bus.ocup_o  = w_ocup;
endmodule
`default_nettype wire

// File: tb/tb_vc_input_buffer_mc.sv
`default_nettype none
// ============================================================
// Module  : tb_vc_input_buffer_mc
// Brief   : Bench driving a PKT_ARB=0 and a PKT_ARB=1 instance in parallel.
// Revision: 1.0
// ============================================================
module tb_vc_input_buffer_mc;
  typedef logic [33:0] flit_t;

  typedef struct packed {
    bit         rst;
    bit         vld;
    logic [1:0] vc;
    flit_t      fd;
    bit         rdy;
    bit         e_vld;
    logic [1:0] e_vc;
    flit_t      e_fd;
    logic [3:0] e_rdy;
    logic [11:0] e_ocup;
  } tv_t;

  typedef struct packed {
    bit          v;
    logic [1:0]  c;
    flit_t       f;
    logic [3:0]  r;
    logic [11:0] o;
  } exp_t;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic [1:0] vc_id = '0;
  flit_t      fdata = '0;
  logic       valid = 1'b0;
  logic       ready = 1'b0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  vc_input_buffer_mc_if #(.NUM_VC(4), .FIFO_DEPTH(4), .FLIT_WIDTH(34)) if0 ();
  vc_input_buffer_mc_if #(.NUM_VC(4), .FIFO_DEPTH(4), .FLIT_WIDTH(34)) if1 ();

  assign if0.vc_id_i = vc_id;
  assign if0.fdata_i = fdata;
  assign if0.valid_i = valid;
  assign if0.ready_i = ready;
  assign if1.vc_id_i = vc_id;
  assign if1.fdata_i = fdata;
  assign if1.valid_i = valid;
  assign if1.ready_i = ready;

  vc_input_buffer_mc #(.NUM_VC(4), .FIFO_DEPTH(4), .FLIT_WIDTH(34), .PKT_ARB(0)) u_dut0 (
    .clk(clk), .arst(arst), .bus(if0));
  vc_input_buffer_mc #(.NUM_VC(4), .FIFO_DEPTH(4), .FLIT_WIDTH(34), .PKT_ARB(1)) u_dut1 (
    .clk(clk), .arst(arst), .bus(if1));

  function automatic flit_t fl(logic [1:0] t, logic [31:0] p);
    return {t, p};
  endfunction

  function automatic tv_t mk(bit r, bit v, logic [1:0] c, flit_t f, bit rd,
                             bit ev, logic [1:0] ec, flit_t ef, logic [3:0] er, logic [11:0] eo);
    tv_t t;
    t.rst = r; t.vld = v; t.vc = c; t.fd = f; t.rdy = rd;
    t.e_vld = ev; t.e_vc = ec; t.e_fd = ef; t.e_rdy = er; t.e_ocup = eo;
    return t;
  endfunction

  function automatic exp_t mke(bit v, logic [1:0] c, flit_t f, logic [3:0] r, logic [11:0] o);
    exp_t e;
    e.v = v; e.c = c; e.f = f; e.r = r; e.o = o;
    return e;
  endfunction

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask

  task automatic check_dut(int d, string tag, bit ev, logic [1:0] ec, flit_t ef,
                           logic [3:0] er, logic [11:0] eo);
    logic av; logic [1:0] ac; flit_t af; logic [3:0] ar; logic [11:0] ao;
    if (d == 0) begin
      av = if0.valid_o; ac = if0.vc_id_o; af = if0.fdata_o; ar = if0.ready_o; ao = if0.ocup_o;
    end else begin
      av = if1.valid_o; ac = if1.vc_id_o; af = if1.fdata_o; ar = if1.ready_o; ao = if1.ocup_o;
    end
    chk({tag, "_valid"}, 64'(av), 64'(ev));
    chk({tag, "_vcid"},  64'(ac), 64'(ec));
    chk({tag, "_fdata"}, 64'(af), 64'(ef));
    chk({tag, "_ready"}, 64'(ar), 64'(er));
    chk({tag, "_ocup"},  64'(ao), 64'(eo));
  endtask

  task automatic set_in(bit r, bit v, logic [1:0] c, flit_t f, bit rd);
    arst = r; valid = v; vc_id = c; fdata = f; ready = rd;
    #1;
  endtask

  task automatic next_cyc();
    @(negedge clk);
  endtask

  // Reference model: per-VC flit queues plus arbitration bookkeeping.
  flit_t mq [2][4][$];
  bit    m_lk [2][4];
  int    m_rr [2];
  int    m_hv [2];
  int    m_pv [2];
  bit    m_hold [2];
  bit    m_pkt [2];

  task automatic model_clear(int d);
    for (int v = 0; v < 4; v++) begin
      mq[d][v].delete();
      m_lk[d][v] = 1'b0;
    end
    m_rr[d] = 0; m_hv[d] = 0; m_pv[d] = 0; m_hold[d] = 1'b0; m_pkt[d] = 1'b0;
  endtask

  task automatic model_step(int cyc);
    for (int d = 0; d < 2; d++) begin
      logic [3:0] er; logic [11:0] eo; logic [1:0] it; flit_t ef; flit_t out;
      bit ev; int g;
      it = fdata[33:32];
      for (int v = 0; v < 4; v++) begin
        er[v] = (mq[d][v].size() < 4) && !(m_lk[d][v] && (it == 2'b00 || it == 2'b11));
        eo[v*3 +: 3] = 3'(mq[d][v].size());
      end
      ev = 1'b0; g = 0;
      if (m_pkt[d]) begin
        g = m_pv[d]; ev = (mq[d][g].size() > 0);
      end else if (m_hold[d]) begin
        g = m_hv[d]; ev = (mq[d][g].size() > 0);
      end else begin
        for (int i = 0; i < 4; i++) begin
          int c;
          c = (m_rr[d] + i) % 4;
          if (!ev && mq[d][c].size() > 0) begin ev = 1'b1; g = c; end
        end
      end
      ef = '0;
      if (ev) ef = mq[d][g][0];
      check_dut(d, $sformatf("rnd%0d_d%0d", cyc, d), ev, ev ? 2'(g) : 2'b00, ef, er, eo);
      if (arst) begin
        model_clear(d);
      end else begin
        if (valid && er[vc_id]) begin
          mq[d][vc_id].push_back(fdata);
          if (it == 2'b00)      m_lk[d][vc_id] = 1'b1;
          else if (it == 2'b10) m_lk[d][vc_id] = 1'b0;
        end
        if (ev && ready) begin
          out = mq[d][g].pop_front();
          if (m_pkt[d]) begin
            if (out[33:32] == 2'b10) begin m_pkt[d] = 1'b0; m_rr[d] = (g + 1) % 4; end
          end else if (d == 1 && out[33:32] == 2'b00) begin
            m_pkt[d] = 1'b1; m_pv[d] = g;
          end else begin
            m_rr[d] = (g + 1) % 4;
          end
        end
        m_hold[d] = ev && !ready;
        m_hv[d] = g;
      end
    end
  endtask

  tv_t  tv [27];
  exp_t e_rr [5];
  exp_t e_p0 [8];
  exp_t e_p1 [8];
  bit    p_v  [8];
  flit_t p_fd [8];

  initial begin
    // Fill VC2, overflow attempt, drain.
    tv[0]  = mk(0,1,2,fl(2'b01,1),0, 0,0,'0,              4'hF,   12'h000);
    tv[1]  = mk(0,1,2,fl(2'b01,2),0, 1,2,fl(2'b01,1),     4'hF,   12'h040);
    tv[2]  = mk(0,1,2,fl(2'b01,3),0, 1,2,fl(2'b01,1),     4'hF,   12'h080);
    tv[3]  = mk(0,1,2,fl(2'b01,4),0, 1,2,fl(2'b01,1),     4'hF,   12'h0C0);
    tv[4]  = mk(0,1,2,fl(2'b01,5),0, 1,2,fl(2'b01,1),     4'b1011,12'h100);
    tv[5]  = mk(0,0,0,'0,1,          1,2,fl(2'b01,1),     4'b1011,12'h100);
    tv[6]  = mk(0,0,0,'0,1,          1,2,fl(2'b01,2),     4'hF,   12'h0C0);
    tv[7]  = mk(0,0,0,'0,1,          1,2,fl(2'b01,3),     4'hF,   12'h080);
    tv[8]  = mk(0,0,0,'0,1,          1,2,fl(2'b01,4),     4'hF,   12'h040);
    tv[9]  = mk(0,0,0,'0,1,          0,0,'0,              4'hF,   12'h000);
    // Route lock on VC1.
    tv[10] = mk(0,1,1,fl(2'b00,'hA),0,  0,0,'0,           4'hF,   12'h000);
    tv[11] = mk(0,0,1,fl(2'b00,'hB),0,  1,1,fl(2'b00,'hA),4'b1101,12'h008);
    tv[12] = mk(0,0,1,fl(2'b11,'hC),0,  1,1,fl(2'b00,'hA),4'b1101,12'h008);
    tv[13] = mk(0,0,1,fl(2'b01,'hD),0,  1,1,fl(2'b00,'hA),4'hF,   12'h008);
    tv[14] = mk(0,1,1,fl(2'b10,'hE),0,  1,1,fl(2'b00,'hA),4'hF,   12'h008);
    tv[15] = mk(0,1,1,fl(2'b00,'hF),0,  1,1,fl(2'b00,'hA),4'hF,   12'h010);
    tv[16] = mk(0,0,1,fl(2'b00,0),0,    1,1,fl(2'b00,'hA),4'b1101,12'h018);
    // Mid-traffic reset.
    tv[17] = mk(1,1,0,fl(2'b11,'h77),1, 1,1,fl(2'b00,'hA),4'b1101,12'h018);
    tv[18] = mk(0,0,0,'0,1,             0,0,'0,           4'hF,   12'h000);
    tv[19] = mk(0,0,0,'0,1,             0,0,'0,           4'hF,   12'h000);
    // Backpressure hold: VC1 must not be preempted by VC0.
    tv[20] = mk(0,1,1,fl(2'b11,'hA1),0, 0,0,'0,             4'hF,12'h000);
    tv[21] = mk(0,0,0,'0,0,             1,1,fl(2'b11,'hA1), 4'hF,12'h008);
    tv[22] = mk(0,1,0,fl(2'b11,'hB0),0, 1,1,fl(2'b11,'hA1), 4'hF,12'h008);
    tv[23] = mk(0,0,0,'0,0,             1,1,fl(2'b11,'hA1), 4'hF,12'h009);
    tv[24] = mk(0,0,0,'0,1,             1,1,fl(2'b11,'hA1), 4'hF,12'h009);
    tv[25] = mk(0,0,0,'0,1,             1,0,fl(2'b11,'hB0), 4'hF,12'h001);
    tv[26] = mk(0,0,0,'0,1,             0,0,'0,             4'hF,12'h000);

    e_rr[0] = mke(1,0,fl(2'b11,1),4'hF,12'h402);
    e_rr[1] = mke(1,3,fl(2'b11,3),4'hF,12'h401);
    e_rr[2] = mke(1,0,fl(2'b11,2),4'hF,12'h201);
    e_rr[3] = mke(1,3,fl(2'b11,4),4'hF,12'h200);
    e_rr[4] = mke(0,0,'0,         4'hF,12'h000);

    for (int i = 0; i < 8; i++) begin p_v[i] = 1'b0; p_fd[i] = '0; end
    p_v[3] = 1'b1; p_fd[3] = fl(2'b01,'h61);
    p_v[4] = 1'b1; p_fd[4] = fl(2'b10,'h62);
    e_p1[0] = mke(1,0,fl(2'b00,'h60),4'b1110,12'h009);
    e_p1[1] = mke(0,0,'0,            4'b1110,12'h008);
    e_p1[2] = mke(0,0,'0,            4'b1110,12'h008);
    e_p1[3] = mke(0,0,'0,            4'hF,   12'h008);
    e_p1[4] = mke(1,0,fl(2'b01,'h61),4'hF,   12'h009);
    e_p1[5] = mke(1,0,fl(2'b10,'h62),4'hF,   12'h009);
    e_p1[6] = mke(1,1,fl(2'b11,'h51),4'hF,   12'h008);
    e_p1[7] = mke(0,0,'0,            4'hF,   12'h000);
    e_p0[0] = mke(1,0,fl(2'b00,'h60),4'b1110,12'h009);
    e_p0[1] = mke(1,1,fl(2'b11,'h51),4'b1110,12'h008);
    e_p0[2] = mke(0,0,'0,            4'b1110,12'h000);
    e_p0[3] = mke(0,0,'0,            4'hF,   12'h000);
    e_p0[4] = mke(1,0,fl(2'b01,'h61),4'hF,   12'h001);
    e_p0[5] = mke(1,0,fl(2'b10,'h62),4'hF,   12'h001);
    e_p0[6] = mke(0,0,'0,            4'hF,   12'h000);
    e_p0[7] = mke(0,0,'0,            4'hF,   12'h000);

    next_cyc();
    next_cyc();

    for (int i = 0; i < 27; i++) begin
      set_in(tv[i].rst, tv[i].vld, tv[i].vc, tv[i].fd, tv[i].rdy);
      for (int d = 0; d < 2; d++)
        check_dut(d, $sformatf("vec%0d_d%0d", i, d), tv[i].e_vld, tv[i].e_vc,
                  tv[i].e_fd, tv[i].e_rdy, tv[i].e_ocup);
      next_cyc();
    end

    // Round robin between VC0 and VC3 with single-flit packets.
    set_in(1,0,0,'0,0); next_cyc();
    set_in(0,1,0,fl(2'b11,1),0); next_cyc();
    set_in(0,1,0,fl(2'b11,2),0); next_cyc();
    set_in(0,1,3,fl(2'b11,3),0); next_cyc();
    set_in(0,1,3,fl(2'b11,4),0); next_cyc();
    for (int k = 0; k < 5; k++) begin
      set_in(0,0,0,'0,1);
      for (int d = 0; d < 2; d++)
        check_dut(d, $sformatf("rr%0d_d%0d", k, d), e_rr[k].v, e_rr[k].c, e_rr[k].f,
                  e_rr[k].r, e_rr[k].o);
      next_cyc();
    end

    // Wormhole packet on VC0 with a late body; VC1 single waits in PKT_ARB=1.
    set_in(1,0,0,'0,0); next_cyc();
    set_in(0,1,0,fl(2'b00,'h60),0); next_cyc();
    set_in(0,1,1,fl(2'b11,'h51),0); next_cyc();
    for (int k = 0; k < 8; k++) begin
      set_in(0, p_v[k], 2'd0, p_fd[k], 1);
      check_dut(0, $sformatf("pkt%0d_d0", k), e_p0[k].v, e_p0[k].c, e_p0[k].f, e_p0[k].r, e_p0[k].o);
      check_dut(1, $sformatf("pkt%0d_d1", k), e_p1[k].v, e_p1[k].c, e_p1[k].f, e_p1[k].r, e_p1[k].o);
      next_cyc();
    end

    // Randomized traffic against the queue model.
    set_in(1,0,0,'0,0);
    model_clear(0);
    model_clear(1);
    next_cyc();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      set_in(($urandom_range(0, 299) == 0),
             ($urandom_range(0, 9) < 7),
             2'($urandom_range(0, 3)),
             {2'($urandom_range(0, 3)), 32'($urandom)},
             ($urandom_range(0, 9) < 5));
      model_step(cyc);
      next_cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
